fp_divider: RTL and testbench
=============================

# fp_divider

Multi-cycle IEEE-754 single-precision divider computing `a / b` with one quotient bit per cycle (restoring division), start/done handshake, truncation (no rounding). Inverse companion of the floating-point multiplier in the FPU datapath. Gives the coprocessor-1 `div.s` path a small-area divider, with the same special-value encodings and overflow/underflow flags as the rest of the FP unit.

## Interface
- No parameters. Format fixed at binary32.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; accepted only in IDLE.
- `a`  in  32  dividend; sampled on the accepted `start` edge.
- `b`  in  32  divisor; sampled on the accepted `start` edge.
- `busy`  out  1  high from the cycle after acceptance through the `done` cycle inclusive.
- `done`  out  1  one-cycle pulse; `result` and flags are valid from this cycle on.
- `result`  out  32  quotient; registered, held until the next `done`.
- `overflow`  out  1  exponent overflow; registered, held with `result`.
- `underflow`  out  1  exponent underflow; registered, held with `result`.
- `div_by_zero`  out  1  finite nonzero / zero; registered, held with `result`.

## Operation
- Classification on the latched operands:
  - zero: exp==0, covering ±0. Exp==0 with mantissa≠0 (denormal) is flushed to zero.
  - inf: exp==255 and mant==0.
  - NaN: exp==255 and mant≠0.
- Special cases, resolved in CLASSIFY:
  - Either operand NaN → `7FC0_0000`.
  - 0/0 or inf/inf → `7FC0_0000`.
  - finite/0 → `{sa^sb, 8'hFF, 23'h0}` with `div_by_zero`=1.
  - inf/finite → signed inf.
  - 0/nonzero or finite/inf → `0000_0000`.
- Normal path:
  - sign = sa^sb.
  - 10-bit signed exponent `e = ea - eb + 127`.
  - Mantissas `ma={1,fa}` and `mb={1,fb}`, 24 bits each.
- Restoring division:
  - rem (25 bits) initialised to ma.
  - 25 iterations, one per cycle: if rem ≥ mb then `q_i=1` and `rem -= mb`, else `q_i=0`; then `rem <<= 1`.
  - q is shifted in MSB-first; `q[24]` is the integer bit.
- Normalise:
  - If `q[24]`=1: `frac = q[23:1]`, exponent e.
  - Else: `frac = q[22:0]`, exponent e−1.
  - Remaining bits are discarded (truncation).
- Range check on the final exponent:
  - ≥255 → signed inf, `overflow`=1.
  - ≤0 → `0000_0000`, `underflow`=1.
  - Otherwise pack `{sign, e[7:0], frac}`.
- At most one flag is set per result. All flags clear on each new `done`.

## Timing
- FSM states: IDLE → CLASSIFY → DIVIDE → NORM → DONE → IDLE.
  - CLASSIFY on a special case → DONE directly.
  - DIVIDE holds for 25 cycles, counted by a 5-bit counter (0..24).
- Latency, with cycle 0 = accepted `start`:
  - special: `done` at cycle 2.
  - normal: `done` at cycle 28 (1 CLASSIFY + 25 DIVIDE + 1 NORM + DONE).
- `start` while not in IDLE (including the DONE cycle) is ignored; operands are not re-sampled.
- Earliest back-to-back `start` is the cycle after `done`.
- Reset values:
  - state=IDLE, counter=0.
  - `busy`=0, `done`=0, `result`=`0000_0000`.
  - `overflow`, `underflow`, `div_by_zero`=0.
- `reset` mid-operation aborts immediately: no `done` pulse, and outputs return to reset values.
- `a`/`b` may change freely after the acceptance cycle.

## Structure
- Shared package `fp_consts`:
  - QNaN `7FC0_0000`, ±infinity, zero.
  - Exponent bias 127, exponent-all-ones 255.
  - Field-width constants.
  - Classification enum {ZERO, NORMAL, INF, NAN}.
- The FSM state enum lives locally in `fp_divider`.
- One sub-module, `fp_mnts_div_step`: combinational single restoring step.
  - Inputs: rem (25 bits), mb (24 bits).
  - Outputs: next rem, q bit.
- FSM, counter and operand/result registers stay in `fp_divider`.

## Test plan
- 6.0/2.0: `a=40C0_0000`, `b=4000_0000` → `result=4040_0000`, no flags, `done` exactly at cycle 28, `busy` high cycles 1–28.
- 1.0/3.0: `3F80_0000`/`4040_0000` → `3EAA_AAAA` (truncated, not `…AB`). Then −1.0/3.0 (`BF80_0000`) → `BEAA_AAAA`.
- Specials, each with `done` at cycle 2:
  - 1.0/0 → `7F80_0000`, `div_by_zero`=1.
  - `BF80_0000`/0 → `FF80_0000`, `div_by_zero`=1.
  - 0/0 → `7FC0_0000`.
  - `7F80_0000`/`7F80_0000` → `7FC0_0000`.
  - `7FA0_0000`/1.0 → `7FC0_0000`.
- Range:
  - `7F00_0000`/`3E80_0000` → `7F80_0000`, `overflow`=1.
  - `0080_0000`/`4000_0000` → `0000_0000`, `underflow`=1.
- Handshake:
  - Pulse `start` with new operands at cycles 5 and 28 of an operation → both ignored; `result` is that of the first operands.
  - A new `start` at cycle 29 is accepted.
- Reset at cycle 10 of a normal divide → `busy`=0 and `result`=0 immediately, no `done` ever, next `start` runs normally.

Source files
------------

// File: rtl/fp_consts.sv
// Shared binary32 constants, operand classification enum and classifier for the FP unit.
package fp_consts;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;

  localparam logic [EXP_W-1:0] EXP_BIAS = 8'd127;
  localparam logic [EXP_W-1:0] EXP_ONES = 8'd255;

  localparam logic [31:0] QNAN      = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF   = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF   = 32'hFF80_0000;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp_class_t;

  // Denormals fall into ZERO: the unit flushes them.
  function automatic fp_class_t fp_classify(input logic [31:0] x);
    logic [EXP_W-1:0]  ex;
    logic [MANT_W-1:0] mt;
    ex = x[30:23];
    mt = x[MANT_W-1:0];
    if (ex == '0)            fp_classify = ZERO;
    else if (ex != EXP_ONES) fp_classify = NORMAL;
    else if (mt == '0)       fp_classify = INF;
    else                     fp_classify = NAN;
  endfunction
endpackage

// File: rtl/fp_mnts_div_step.sv
// One restoring-division step on the 24-bit significands: compare, subtract, shift.
module fp_mnts_div_step
  import fp_consts::*;
(
  input  logic [MANT_W+1:0] rem,
  input  logic [MANT_W:0]   mb,
  output logic [MANT_W+1:0] rem_next,
  output logic              q_bit
);
  logic [MANT_W:0] diff;

  // The difference is always below mb, so it fits in 24 bits and the low bits suffice.
  always_comb begin
    q_bit    = (rem >= {1'b0, mb});
    diff     = q_bit ? (rem[MANT_W:0] - mb) : rem[MANT_W:0];
    rem_next = {diff, 1'b0};
  end
endmodule

// File: rtl/fp_divider.sv
// Multi-cycle binary32 divider: one quotient bit per cycle, truncating, start/done handshake.
module fp_divider
  import fp_consts::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CLASSIFY = 3'd1;
  localparam logic [2:0] DIVIDE   = 3'd2;
  localparam logic [2:0] NORM     = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;
  localparam logic [4:0] LAST_STEP = 5'd24;

  logic [2:0]        state;
  logic [4:0]        cnt;
  logic [31:0]       a_r, b_r;
  logic              sign;
  logic [9:0]        e;
  logic [MANT_W+1:0] rem;
  logic [MANT_W:0]   mb;
  logic [MANT_W+1:0] q;

  fp_class_t   cls_a, cls_b;
  logic        special, spec_dbz;
  logic [31:0] spec_res;
  logic [9:0]  e_calc, e_adj;
  logic [MANT_W-1:0] frac;
  logic        ovf_n, unf_n;
  logic [31:0] norm_res;
  logic [MANT_W+1:0] rem_next;
  logic        q_bit;

  fp_mnts_div_step u_step (
    .rem      (rem),
    .mb       (mb),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  assign cls_a  = fp_classify(a_r);
  assign cls_b  = fp_classify(b_r);
  assign e_calc = {2'b00, a_r[30:23]} - {2'b00, b_r[30:23]} + {2'b00, EXP_BIAS};

  // Special-value resolution, in priority order.
  always_comb begin
    special  = 1'b1;
    spec_dbz = 1'b0;
    spec_res = ZERO_WORD;
    if (cls_a == NAN || cls_b == NAN)
      spec_res = QNAN;
    else if ((cls_a == ZERO && cls_b == ZERO) || (cls_a == INF && cls_b == INF))
      spec_res = QNAN;
    else if (cls_a == INF)
      spec_res = (a_r[31] ^ b_r[31]) ? NEG_INF : POS_INF;
    else if (cls_b == ZERO) begin
      spec_res = (a_r[31] ^ b_r[31]) ? NEG_INF : POS_INF;
      spec_dbz = 1'b1;
    end else if (cls_a == ZERO || cls_b == INF)
      spec_res = ZERO_WORD;
    else
      special = 1'b0;
  end

  // Quotient of two normals lies in (0.5, 2): at most a one-bit normalise shift.
  always_comb begin
    e_adj = q[MANT_W+1] ? e : (e - 10'd1);
    frac  = q[MANT_W+1] ? q[MANT_W:1] : q[MANT_W-1:0];
    ovf_n = ($signed(e_adj) >= $signed(10'd255));
    unf_n = ($signed(e_adj) <= $signed(10'd0));
    if (ovf_n)      norm_res = sign ? NEG_INF : POS_INF;
    else if (unf_n) norm_res = ZERO_WORD;
    else            norm_res = {sign, e_adj[EXP_W-1:0], frac};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      a_r         <= '0;
      b_r         <= '0;
      sign        <= 1'b0;
      e           <= '0;
      rem         <= '0;
      mb          <= '0;
      q           <= '0;
      result      <= ZERO_WORD;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_r   <= a;
          b_r   <= b;
          state <= CLASSIFY;
        end
        CLASSIFY: begin
          sign <= a_r[31] ^ b_r[31];
          e    <= e_calc;
          rem  <= {2'b01, a_r[MANT_W-1:0]};
          mb   <= {1'b1, b_r[MANT_W-1:0]};
          q    <= '0;
          cnt  <= '0;
          if (special) begin
            result      <= spec_res;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            div_by_zero <= spec_dbz;
            state       <= DONE;
          end else begin
            state <= DIVIDE;
          end
        end
        DIVIDE: begin
          rem <= rem_next;
          q   <= {q[MANT_W:0], q_bit};
          if (cnt == LAST_STEP) begin
            cnt   <= '0;
            state <= NORM;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        NORM: begin
          result      <= norm_res;
          overflow    <= ovf_n;
          underflow   <= unf_n;
          div_by_zero <= 1'b0;
          state       <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_divider.sv
// Directed-vector bench for fp_divider: values, flags, latency, handshake and reset abort.
module tb_fp_divider;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] a, b;
  logic        busy, done, overflow, underflow, div_by_zero;
  logic [31:0] result;

  fp_divider dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .overflow    (overflow),
    .underflow   (underflow),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        dbz;
    int          lat;
    string       name;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Caller is at a negedge. Glitch cycles pulse start with 1.0/1.0 operands mid-operation.
  task automatic run_op(input vec_t v, input int g1, input int g2);
    int lat;
    int bad_busy;
    lat = 0;
    bad_busy = 0;
    a = v.a;
    b = v.b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 32'h3F80_0000;
    b = 32'h3F80_0000;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = (k == g1 || k == g2);
      if (!busy && bad_busy == 0) bad_busy = k;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk({v.name, " latency"}, 32'(lat), 32'(v.lat));
    chk({v.name, " first_cycle_busy_low"}, 32'(bad_busy), 32'd0);
    chk({v.name, " result"}, result, v.res);
    chk({v.name, " overflow"}, {31'd0, overflow}, {31'd0, v.ovf});
    chk({v.name, " underflow"}, {31'd0, underflow}, {31'd0, v.unf});
    chk({v.name, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, v.dbz});
    @(negedge clk);
    start = 1'b0;
    chk({v.name, " done_after"}, {31'd0, done}, 32'd0);
    chk({v.name, " busy_after"}, {31'd0, busy}, 32'd0);
    chk({v.name, " result_held"}, result, v.res);
  endtask

  initial begin
    int seen;
    vecs[0]  = '{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 0, 0, 0, 28, "6/2"};
    vecs[1]  = '{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 0, 0, 0, 28, "1/3"};
    vecs[2]  = '{32'hBF80_0000, 32'h4040_0000, 32'hBEAA_AAAA, 0, 0, 0, 28, "-1/3"};
    vecs[3]  = '{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 0, 0, 1, 2,  "1/0"};
    vecs[4]  = '{32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 0, 0, 1, 2,  "-1/0"};
    vecs[5]  = '{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 0, 0, 0, 2,  "0/0"};
    vecs[6]  = '{32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 0, 0, 0, 2,  "inf/inf"};
    vecs[7]  = '{32'h7FA0_0000, 32'h3F80_0000, 32'h7FC0_0000, 0, 0, 0, 2,  "nan/1"};
    vecs[8]  = '{32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 1, 0, 0, 28, "ovf"};
    vecs[9]  = '{32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 0, 1, 0, 28, "unf"};
    vecs[10] = '{32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 0, 0, 0, 2,  "0/2"};
    vecs[11] = '{32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000, 0, 0, 0, 2,  "1/inf"};
    vecs[12] = '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 0, 0, 0, 2,  "-inf/2"};
    vecs[13] = '{32'h4000_0000, 32'hC080_0000, 32'hBF00_0000, 0, 0, 0, 28, "2/-4"};
    vecs[14] = '{32'h0040_0000, 32'h3F80_0000, 32'h0000_0000, 0, 0, 0, 2,  "denorm/1"};
    vecs[15] = '{32'h3F80_0000, 32'h7FC1_2345, 32'h7FC0_0000, 0, 0, 0, 2,  "1/nan"};

    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", result, 32'h0);
    chk("reset overflow", {31'd0, overflow}, 32'd0);
    chk("reset underflow", {31'd0, underflow}, 32'd0);
    chk("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) run_op(vecs[i], -1, -1);

    // Starts at cycles 5 and 28 are ignored; the start at cycle 29 is accepted.
    run_op(vecs[0], 5, 28);
    run_op(vecs[1], -1, -1);

    // Reset at cycle 10 of a normal divide aborts it.
    a = 32'h40C0_0000;
    b = 32'h4000_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort result", result, 32'h0);
    chk("abort flags", {29'd0, overflow, underflow, div_by_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("abort no_done_or_busy", 32'(seen), 32'd0);
    run_op(vecs[13], -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
